// File: rtl/daisy_pkg.sv
// Shared types for the DAISY event capture path: one buffered event entry.
package daisy_pkg;

    localparam int DAISY_ID_W   = 4;
    localparam int DAISY_TS_W   = 32;
    localparam int DAISY_DATA_W = 32;

    typedef struct packed {
        logic                    lost;
        logic [DAISY_ID_W-1:0]   id;
        logic [DAISY_TS_W-1:0]   ts;
        logic [DAISY_DATA_W-1:0] data;
    } daisy_evt_t;

    localparam int DAISY_EVT_W = $bits(daisy_evt_t);

endpackage

// File: rtl/daisy_sync_fifo.sv
// Generic synchronous first-word-fall-through FIFO; head word is read straight
// out of registered storage at the read pointer.
module daisy_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wrPtr_q;
    logic [AW:0]      rdPtr_q;
    logic             doPush;
    logic             doPop;

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign doPop  = pop_i & ~empty_o;
    assign doPush = push_i & (~full_o | doPop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + (AW+1)'(1);
            if (doPop)  rdPtr_q <= rdPtr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (doPush) mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
    end

    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                     (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign level_o = wrPtr_q - rdPtr_q;
    assign rdata_o = mem_q[rdPtr_q[AW-1:0]];

endmodule

// File: rtl/daisy_evt_capture.sv
// Timestamps DUT event strobes, buffers them for the DPI monitor and tracks
// events lost to overflow so software can spot gaps in the stream.
module daisy_evt_capture
    import daisy_pkg::*;
#(
    parameter int DATA_W = DAISY_DATA_W,
    parameter int ID_W   = DAISY_ID_W,
    parameter int TS_W   = DAISY_TS_W,
    parameter int DEPTH  = 16,
    parameter int OVF_W  = 16
) (
    input  logic                   clk,
    input  logic                   rest,
    input  logic                   enable,
    input  logic                   evt_valid,
    input  logic [ID_W-1:0]        evt_id,
    input  logic [DATA_W-1:0]      evt_data,
    output logic                   mon_valid,
    input  logic                   mon_ready,
    output logic [ID_W-1:0]        mon_id,
    output logic [DATA_W-1:0]      mon_data,
    output logic [TS_W-1:0]        mon_ts,
    output logic                   mon_lost,
    output logic [$clog2(DEPTH):0] level,
    output logic [OVF_W-1:0]       ovf_cnt
);

    logic [TS_W-1:0]  ts_q;
    logic [TS_W-1:0]  ts_d;
    logic [OVF_W-1:0] ovfCnt_q;
    logic [OVF_W-1:0] ovfCnt_d;
    logic             lostPending_q;
    logic             lostPending_d;

    logic       fifoFull;
    logic       fifoEmpty;
    logic       pop;
    logic       push;
    logic       drop;
    daisy_evt_t pushEntry;
    daisy_evt_t headEntry;

    assign pop  = mon_valid & mon_ready;
    assign push = enable & evt_valid & (~fifoFull | pop);
    assign drop = enable & evt_valid & fifoFull & ~pop;

    always_comb begin
        pushEntry      = '0;
        pushEntry.lost = lostPending_q;
        pushEntry.id   = evt_id;
        pushEntry.ts   = ts_q;
        pushEntry.data = evt_data;
    end

    // The lost flag rides on the first entry accepted after any drop.
    always_comb begin
        ts_d          = ts_q + TS_W'(1);
        ovfCnt_d      = ovfCnt_q;
        lostPending_d = lostPending_q;
        if (drop) begin
            lostPending_d = 1'b1;
            if (ovfCnt_q != '1) ovfCnt_d = ovfCnt_q + OVF_W'(1);
        end else if (push) begin
            lostPending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            ts_q          <= '0;
            ovfCnt_q      <= '0;
            lostPending_q <= 1'b0;
        end else begin
            ts_q          <= ts_d;
            ovfCnt_q      <= ovfCnt_d;
            lostPending_q <= lostPending_d;
        end
    end

    daisy_sync_fifo #(
        .WIDTH (DAISY_EVT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rest),
        .push_i  (push),
        .wdata_i (pushEntry),
        .pop_i   (pop),
        .rdata_o (headEntry),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .level_o (level)
    );

    // Storage is never cleared, so head fields are masked while nothing is valid.
    assign mon_valid = ~fifoEmpty;
    assign mon_id    = mon_valid ? headEntry.id   : '0;
    assign mon_data  = mon_valid ? headEntry.data : '0;
    assign mon_ts    = mon_valid ? headEntry.ts   : '0;
    assign mon_lost  = mon_valid & headEntry.lost;
    assign ovf_cnt   = ovfCnt_q;

endmodule

// File: tb/tb_daisy_evt_capture.sv
// Directed self-checking bench for daisy_evt_capture; inputs change and outputs
// are sampled on the falling clock edge.
module tb_daisy_evt_capture;

    logic        clk;
    logic        rest;
    logic        enable;
    logic        evtValid;
    logic [3:0]  evtId;
    logic [31:0] evtData;
    logic        monValid;
    logic        monReady;
    logic [3:0]  monId;
    logic [31:0] monData;
    logic [31:0] monTs;
    logic        monLost;
    logic [4:0]  level;
    logic [15:0] ovfCnt;

    int checks   = 0;
    int failures = 0;

    daisy_evt_capture dut (
        .clk       (clk),
        .rest      (rest),
        .enable    (enable),
        .evt_valid (evtValid),
        .evt_id    (evtId),
        .evt_data  (evtData),
        .mon_valid (monValid),
        .mon_ready (monReady),
        .mon_id    (monId),
        .mon_data  (monData),
        .mon_ts    (monTs),
        .mon_lost  (monLost),
        .level     (level),
        .ovf_cnt   (ovfCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] id, input logic [31:0] data);
        evtValid = v;
        evtId    = id;
        evtData  = data;
    endtask

    initial begin
        rest     = 1'b1;
        enable   = 1'b0;
        monReady = 1'b0;
        applyStimulus(1'b0, 4'h0, 32'h0);
        repeat (2) @(negedge clk);

        // Reset state
        checkOutput("rst_valid", monValid, 0);
        checkOutput("rst_level", level, 0);
        checkOutput("rst_ovf", ovfCnt, 0);
        checkOutput("rst_ts", monTs, 0);
        checkOutput("rst_data", monData, 0);
        checkOutput("rst_lost", monLost, 0);

        // Single event in cycle 10 after release
        rest     = 1'b0;
        enable   = 1'b1;
        monReady = 1'b1;
        repeat (10) @(negedge clk);
        applyStimulus(1'b1, 4'h3, 32'hA5A5_0001);
        @(negedge clk);
        applyStimulus(1'b0, 4'h0, 32'h0);
        checkOutput("t1_valid", monValid, 1);
        checkOutput("t1_ts", monTs, 10);
        checkOutput("t1_lost", monLost, 0);
        checkOutput("t1_id", monId, 3);
        checkOutput("t1_data", monData, 32'hA5A5_0001);
        checkOutput("t1_level1", level, 1);
        @(negedge clk);
        checkOutput("t1_valid_gone", monValid, 0);
        checkOutput("t1_level0", level, 0);

        // Fill, overflow by one, drain, lost marking
        monReady = 1'b0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 4'(i), 32'(i));
            @(negedge clk);
        end
        checkOutput("t2_level_full", level, 16);
        applyStimulus(1'b1, 4'hF, 32'd99);
        @(negedge clk);
        applyStimulus(1'b0, 4'h0, 32'h0);
        checkOutput("t2_ovf1", ovfCnt, 1);
        checkOutput("t2_level_still_full", level, 16);
        monReady = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checkOutput("t2_drain_data", monData, 64'(i));
            checkOutput("t2_drain_lost", monLost, 0);
            @(negedge clk);
        end
        checkOutput("t2_drained", level, 0);
        monReady = 1'b0;
        applyStimulus(1'b1, 4'h1, 32'd100);
        @(negedge clk);
        applyStimulus(1'b1, 4'h2, 32'd101);
        checkOutput("t2_after_drop_data", monData, 100);
        checkOutput("t2_after_drop_lost", monLost, 1);
        @(negedge clk);
        applyStimulus(1'b0, 4'h0, 32'h0);
        checkOutput("t2_level2", level, 2);
        monReady = 1'b1;
        @(negedge clk);
        checkOutput("t2_next_data", monData, 101);
        checkOutput("t2_next_lost", monLost, 0);
        @(negedge clk);
        checkOutput("t2_empty", level, 0);
        monReady = 1'b0;

        // Full with simultaneous push and pop for 20 cycles
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 4'h0, 32'(200 + i));
            @(negedge clk);
        end
        for (int j = 0; j < 20; j++) begin
            checkOutput("t3_head", monData, (j < 16) ? 64'(200 + j) : 64'(300 + j - 16));
            checkOutput("t3_level", level, 16);
            checkOutput("t3_ovf", ovfCnt, 1);
            applyStimulus(1'b1, 4'h0, 32'(300 + j));
            monReady = 1'b1;
            @(negedge clk);
        end
        applyStimulus(1'b0, 4'h0, 32'h0);
        for (int k = 0; k < 16; k++) begin
            checkOutput("t3_drain", monData, 64'(304 + k));
            @(negedge clk);
        end
        checkOutput("t3_empty", level, 0);
        monReady = 1'b0;

        // Timestamp wrap and head stability while stalled
        force dut.ts_q = 32'hFFFF_FFFF;
        #1;
        release dut.ts_q;
        applyStimulus(1'b1, 4'h9, 32'h0000_0400);
        @(negedge clk);
        applyStimulus(1'b1, 4'hA, 32'h0000_0401);
        @(negedge clk);
        applyStimulus(1'b0, 4'h0, 32'h0);
        for (int s = 0; s < 5; s++) begin
            checkOutput("t4_hold_data", monData, 32'h0000_0400);
            checkOutput("t4_hold_id", monId, 4'h9);
            checkOutput("t4_hold_ts", monTs, 32'hFFFF_FFFF);
            @(negedge clk);
        end
        monReady = 1'b1;
        @(negedge clk);
        checkOutput("t4_wrap_data", monData, 32'h0000_0401);
        checkOutput("t4_wrap_ts", monTs, 0);
        @(negedge clk);
        checkOutput("t4_empty", level, 0);
        monReady = 1'b0;

        // Disabled strobes, then saturating overflow
        rest = 1'b1;
        @(negedge clk);
        rest = 1'b0;
        checkOutput("t5_rst_ovf", ovfCnt, 0);
        enable = 1'b0;
        applyStimulus(1'b1, 4'h5, 32'h0000_0500);
        repeat (8) @(negedge clk);
        checkOutput("t5_dis_level", level, 0);
        checkOutput("t5_dis_ovf", ovfCnt, 0);
        checkOutput("t5_dis_valid", monValid, 0);
        enable = 1'b1;
        repeat (116) @(negedge clk);
        checkOutput("t5_ovf100", ovfCnt, 100);
        checkOutput("t5_level", level, 16);
        repeat (69900) @(negedge clk);
        checkOutput("t5_ovf_sat", ovfCnt, 16'hFFFF);
        applyStimulus(1'b0, 4'h0, 32'h0);

        // Reset mid-drain, then timestamp restarts from release
        monReady = 1'b1;
        repeat (7) @(negedge clk);
        checkOutput("t6_level9", level, 9);
        rest = 1'b1;
        @(negedge clk);
        checkOutput("t6_valid", monValid, 0);
        checkOutput("t6_level", level, 0);
        checkOutput("t6_ovf", ovfCnt, 0);
        checkOutput("t6_data", monData, 0);
        rest     = 1'b0;
        monReady = 1'b0;
        repeat (5) @(negedge clk);
        applyStimulus(1'b1, 4'h7, 32'h0000_0600);
        @(negedge clk);
        applyStimulus(1'b0, 4'h0, 32'h0);
        checkOutput("t6_ts", monTs, 5);
        checkOutput("t6_lost", monLost, 0);
        checkOutput("t6_id", monId, 4'h7);
        checkOutput("t6_level1", level, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
